mesh_link_endpoint: RTL and testbench
=====================================

MESH_LINK_ENDPOINT -- requirements
Module: mesh_link_endpoint

Interface
REQ-001 Parameter DEPTH, default 2, per-direction buffer entries; SHALL be a power of two and at least 2.
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 tx_data  in  word(32)  tile payload to transmit.
REQ-005 tx_valid  in  1  tile offers tx_data.
REQ-006 tx_ready  out  1  TX buffer can accept; push occurs when tx_valid & tx_ready.
REQ-007 rx_data  out  word(32)  head of RX buffer.
REQ-008 rx_valid  out  1  RX buffer non-empty.
REQ-009 rx_ready  in  1  tile consumes; pop occurs when rx_valid & rx_ready.
REQ-010 send_data  out  word(32)  head of TX buffer, driven onto link.
REQ-011 send_ready  out  1  TX buffer non-empty, word offered to link.
REQ-012 send_done  in  1  peer accepted send_data this cycle.
REQ-013 recv_data  in  word(32)  word from peer.
REQ-014 recv_valid  in  1  peer word transferred into this endpoint this cycle.
REQ-015 recv_ready  out  1  RX buffer not full.
REQ-016 tx_count, rx_count  out  $clog2(DEPTH)+1 each  current TX/RX occupancy.
REQ-017 proto_err  out  1  sticky link-protocol violation flag.

Function
REQ-018 send_ready, send_data, recv_ready, tx_ready, rx_valid, rx_data SHALL be functions of registered state only; no combinational path from any input to any output.
REQ-019 TX: push on tx_valid & tx_ready; pop on send_done & send_ready; order FIFO.
REQ-020 RX: push recv_data on recv_valid & recv_ready; pop on rx_valid & rx_ready; order FIFO.
REQ-021 tx_ready = (tx_count != DEPTH); recv_ready = (rx_count != DEPTH); pop in same cycle SHALL NOT raise ready combinationally.
REQ-022 Simultaneous push and pop on one buffer SHALL leave count unchanged and preserve order, including at count DEPTH-1 and count 1.
REQ-023 Pointers SHALL wrap modulo DEPTH without losing or duplicating entries.
REQ-024 Latency: tile push in cycle N -> send_ready high in N+1; link transfer in N+1 -> peer rx_valid high in N+2.
REQ-025 Sustained throughput SHALL be one word per cycle per direction when neither side back-pressures.
REQ-026 send_done while send_ready low, or recv_valid while recv_ready low, SHALL set proto_err next cycle and SHALL NOT change the affected buffer.
REQ-027 proto_err SHALL remain set until reset.
REQ-028 rx_data/send_data SHALL be held stable while the corresponding valid/ready is high and no pop occurs.

Reset
REQ-029 RST high SHALL asynchronously clear both buffers' pointers and counts and proto_err.
REQ-030 During and after reset: tx_ready=1, recv_ready=1, send_ready=0, rx_valid=0, counts=0, proto_err=0; data outputs don't-care.
REQ-031 Reset mid-transfer SHALL discard all buffered words; no word from before reset SHALL appear after.

Structure
REQ-032 word (32-bit) SHALL come from the shared types package; DEPTH default constant MESH_LINK_DEPTH SHALL live there too.
REQ-033 One sub-module mesh_link_fifo (parameterised DEPTH, word payload, push/pop/full/empty/count) SHALL be instantiated twice, TX and RX.
REQ-034 Two endpoints connect through mesh_link_if, tile_A and tile_B sides.

Verification
REQ-035 Back-to-back: two endpoints linked, push 0x1,0x2,0x3,0x4 on A in consecutive cycles, B rx_ready=1 -> B rx_data 0x1..0x4 in cycles 2..5, no bubbles.
REQ-036 Back-pressure: B rx_ready=0, push 6 words on A with DEPTH=2 -> B rx_count=2, A tx_count=2, A tx_ready=0; release -> all 6 delivered in order.
REQ-037 Wrap: 3*DEPTH+1 words with random rx_ready -> order preserved, counts never exceed DEPTH.
REQ-038 Protocol error: standalone endpoint, send_done=1 with empty TX -> proto_err=1 next cycle, tx_count stays 0, held until RST.
REQ-039 Reset mid-operation: RST asserted with tx_count=2, rx_count=1 -> all counts 0, send_ready=0, rx_valid=0 immediately; next pushed 0xA5 is first delivered word.
REQ-040 Simultaneous push/pop at tx_count=1 over 10 cycles -> tx_count stays 1, data sequence intact.

Source files
------------

// File: rtl/mesh_link_pkg.sv
// Shared types and constants for the mesh link endpoint and its buffers.
package mesh_link_pkg;

  localparam int WORD_W          = 32;
  localparam int MESH_LINK_DEPTH = 2;

  typedef logic [WORD_W-1:0] word_t;

  // Buffer pointers wrap by natural overflow, so depth must be a power of two >= 2.
  function automatic bit depth_is_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/mesh_link_if.sv
// Point-to-point link between two endpoints; a word transfers whenever the
// sender offers one and the receiver has room.
interface mesh_link_if;
  import mesh_link_pkg::*;

  word_t a_send_data, b_send_data;
  word_t a_recv_data, b_recv_data;
  logic  a_send_ready, b_send_ready;
  logic  a_send_done, b_send_done;
  logic  a_recv_valid, b_recv_valid;
  logic  a_recv_ready, b_recv_ready;

  assign b_recv_data  = a_send_data;
  assign b_recv_valid = a_send_ready & b_recv_ready;
  assign a_send_done  = b_recv_valid;

  assign a_recv_data  = b_send_data;
  assign a_recv_valid = b_send_ready & a_recv_ready;
  assign b_send_done  = a_recv_valid;

  modport tile_A (
    output a_send_data, a_send_ready, a_recv_ready,
    input  a_send_done, a_recv_data, a_recv_valid
  );

  modport tile_B (
    output b_send_data, b_send_ready, b_recv_ready,
    input  b_send_done, b_recv_data, b_recv_valid
  );

endinterface

// File: rtl/mesh_link_fifo.sv
// Synchronous FIFO of words; all outputs come straight from registered state.
module mesh_link_fifo
  import mesh_link_pkg::*;
#(
  parameter int DEPTH = MESH_LINK_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WORD_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [WORD_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Requests against a full/empty buffer are dropped here so state can never corrupt.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mesh_link_endpoint.sv
// Tile-side endpoint of a mesh link: a TX buffer toward the peer and an RX
// buffer from the peer, plus a sticky flag for link handshake violations.
module mesh_link_endpoint
  import mesh_link_pkg::*;
#(
  parameter int DEPTH = MESH_LINK_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_W-1:0]       tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [WORD_W-1:0]       rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [WORD_W-1:0]       send_data,
  output logic                    send_ready,
  input  logic                    send_done,
  input  logic [WORD_W-1:0]       recv_data,
  input  logic                    recv_valid,
  output logic                    recv_ready,
  output logic [$clog2(DEPTH):0]  tx_count,
  output logic [$clog2(DEPTH):0]  rx_count,
  output logic                    proto_err
);

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic proto_err_q, proto_err_d;

  assign tx_ready   = ~tx_full;
  assign send_ready = ~tx_empty;
  assign recv_ready = ~rx_full;
  assign rx_valid   = ~rx_empty;
  assign proto_err  = proto_err_q;

  assign tx_push = tx_valid & ~tx_full;
  assign tx_pop  = send_done & ~tx_empty;
  assign rx_push = recv_valid & ~rx_full;
  assign rx_pop  = rx_ready & ~rx_empty;

  mesh_link_fifo #(
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .wdata_i (tx_data),
    .pop_i   (tx_pop),
    .rdata_o (send_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  mesh_link_fifo #(
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .wdata_i (recv_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Peer claiming a word we never offered, or pushing into a full buffer.
  always_comb begin
    proto_err_d = proto_err_q;
    if ((send_done & tx_empty) | (recv_valid & rx_full)) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err_q <= 1'b0;
    else     proto_err_q <= proto_err_d;
  end

endmodule

// File: tb/tb_mesh_link_endpoint.sv
// Bench: two endpoints joined by mesh_link_if plus one standalone endpoint.
module tb_mesh_link_endpoint;
  import mesh_link_pkg::*;

  localparam int D  = MESH_LINK_DEPTH;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesh_link_if link ();

  logic [31:0]   a_tx_data, b_tx_data, a_rx_data, b_rx_data;
  logic          a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready;
  logic          a_rx_valid, b_rx_valid, a_rx_ready, b_rx_ready;
  logic [CW-1:0] a_tx_count, b_tx_count, a_rx_count, b_rx_count;
  logic          a_proto_err, b_proto_err;

  logic [31:0]   s_tx_data, s_rx_data, s_send_data, s_recv_data;
  logic          s_tx_valid, s_tx_ready, s_rx_valid, s_rx_ready;
  logic          s_send_ready, s_send_done, s_recv_valid, s_recv_ready;
  logic [CW-1:0] s_tx_count, s_rx_count;
  logic          s_proto_err;

  mesh_link_endpoint #(.DEPTH(D)) u_a (
    .clk(clk), .rst(rst),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .send_data(link.a_send_data), .send_ready(link.a_send_ready), .send_done(link.a_send_done),
    .recv_data(link.a_recv_data), .recv_valid(link.a_recv_valid), .recv_ready(link.a_recv_ready),
    .tx_count(a_tx_count), .rx_count(a_rx_count), .proto_err(a_proto_err)
  );

  mesh_link_endpoint #(.DEPTH(D)) u_b (
    .clk(clk), .rst(rst),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .send_data(link.b_send_data), .send_ready(link.b_send_ready), .send_done(link.b_send_done),
    .recv_data(link.b_recv_data), .recv_valid(link.b_recv_valid), .recv_ready(link.b_recv_ready),
    .tx_count(b_tx_count), .rx_count(b_rx_count), .proto_err(b_proto_err)
  );

  mesh_link_endpoint #(.DEPTH(D)) u_s (
    .clk(clk), .rst(rst),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(s_tx_ready),
    .rx_data(s_rx_data), .rx_valid(s_rx_valid), .rx_ready(s_rx_ready),
    .send_data(s_send_data), .send_ready(s_send_ready), .send_done(s_send_done),
    .recv_data(s_recv_data), .recv_valid(s_recv_valid), .recv_ready(s_recv_ready),
    .tx_count(s_tx_count), .rx_count(s_rx_count), .proto_err(s_proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: each link direction is an ordered queue of words in flight.
  logic [31:0] exp_ab[$];
  logic [31:0] exp_ba[$];
  int          delivered_ab, delivered_ba;
  logic        last_a_push, last_b_push;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance the linked pair one cycle, scoring deliveries against the model.
  task automatic cycle();
    logic        a_push, b_push, a_pop, b_pop;
    logic [31:0] w;
    a_push = a_tx_valid & a_tx_ready;
    b_push = b_tx_valid & b_tx_ready;
    a_pop  = a_rx_valid & a_rx_ready;
    b_pop  = b_rx_valid & b_rx_ready;
    if (b_pop) begin
      n_checks++;
      if (exp_ab.size() == 0) $display("FAIL ab_order: got %h, required no word", b_rx_data);
      else begin
        w = exp_ab.pop_front();
        if (b_rx_data !== w) $display("FAIL ab_order: got %h, required %h", b_rx_data, w);
        else n_pass++;
      end
      delivered_ab++;
    end
    if (a_pop) begin
      n_checks++;
      if (exp_ba.size() == 0) $display("FAIL ba_order: got %h, required no word", a_rx_data);
      else begin
        w = exp_ba.pop_front();
        if (a_rx_data !== w) $display("FAIL ba_order: got %h, required %h", a_rx_data, w);
        else n_pass++;
      end
      delivered_ba++;
    end
    if (a_push) exp_ab.push_back(a_tx_data);
    if (b_push) exp_ba.push_back(b_tx_data);
    last_a_push = a_push;
    last_b_push = b_push;
    tick();
    n_checks++;
    if ((int'(a_tx_count) + int'(b_rx_count)) != exp_ab.size())
      $display("FAIL ab_inflight: got %0d+%0d, required %0d", a_tx_count, b_rx_count, exp_ab.size());
    else n_pass++;
    n_checks++;
    if ((int'(b_tx_count) + int'(a_rx_count)) != exp_ba.size())
      $display("FAIL ba_inflight: got %0d+%0d, required %0d", b_tx_count, a_rx_count, exp_ba.size());
    else n_pass++;
    n_checks++;
    if (int'(a_tx_count) > D || int'(a_rx_count) > D || int'(b_tx_count) > D || int'(b_rx_count) > D)
      $display("FAIL count_bound: got %0d %0d %0d %0d, required <= %0d",
               a_tx_count, a_rx_count, b_tx_count, b_rx_count, D);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    a_tx_valid = 1'b0; b_tx_valid = 1'b0; a_tx_data = '0; b_tx_data = '0;
    a_rx_ready = 1'b1; b_rx_ready = 1'b1;
    s_tx_valid = 1'b0; s_tx_data = '0; s_rx_ready = 1'b0;
    s_send_done = 1'b0; s_recv_valid = 1'b0; s_recv_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    exp_ab.delete(); exp_ba.delete();
    tick(); tick();
    n_checks++;
    if ({a_tx_ready, link.a_recv_ready, link.a_send_ready, a_rx_valid, a_tx_count, a_rx_count, a_proto_err}
        !== {1'b1, 1'b1, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0})
      $display("FAIL reset_a_during: got %b%b%b%b %0d %0d %b, required 1100 0 0 0", a_tx_ready,
               link.a_recv_ready, link.a_send_ready, a_rx_valid, a_tx_count, a_rx_count, a_proto_err);
    else n_pass++;
    n_checks++;
    if ({s_tx_ready, s_recv_ready, s_send_ready, s_rx_valid, s_tx_count, s_rx_count, s_proto_err}
        !== {1'b1, 1'b1, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0})
      $display("FAIL reset_s_during: got %b%b%b%b %0d %0d %b, required 1100 0 0 0", s_tx_ready,
               s_recv_ready, s_send_ready, s_rx_valid, s_tx_count, s_rx_count, s_proto_err);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({b_tx_ready, link.b_recv_ready, link.b_send_ready, b_rx_valid, b_tx_count, b_rx_count, b_proto_err}
        !== {1'b1, 1'b1, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0})
      $display("FAIL reset_b_after: got %b%b%b%b %0d %0d %b, required 1100 0 0 0", b_tx_ready,
               link.b_recv_ready, link.b_send_ready, b_rx_valid, b_tx_count, b_rx_count, b_proto_err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 7; k++) begin
      a_tx_valid = (k < 4);
      a_tx_data  = 32'(k + 1);
      if (k < 4) begin
        n_checks++;
        if (a_tx_ready !== 1'b1) $display("FAIL b2b_tx_ready c%0d: got %b, required 1", k, a_tx_ready);
        else n_pass++;
      end
      if (k >= 2 && k <= 5) begin
        n_checks++;
        if (b_rx_valid !== 1'b1 || b_rx_data !== 32'(k - 1))
          $display("FAIL b2b_rx c%0d: got v=%b %h, required v=1 %h", k, b_rx_valid, b_rx_data, 32'(k - 1));
        else n_pass++;
      end
      if (k == 1 || k == 6) begin
        n_checks++;
        if (b_rx_valid !== 1'b0) $display("FAIL b2b_bubble c%0d: got rx_valid %b, required 0", k, b_rx_valid);
        else n_pass++;
      end
      cycle();
    end
    a_tx_valid = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    for (int k = 0; k < 12; k++) begin
      a_tx_valid = 1'b1;
      a_tx_data  = $urandom;
      if (k >= 1) begin
        n_checks++;
        if (a_tx_count !== CW'(1)) $display("FAIL simul_count c%0d: got %0d, required 1", k, a_tx_count);
        else n_pass++;
      end
      cycle();
    end
    a_tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    n_checks++;
    if (exp_ab.size() != 0) $display("FAIL simul_drain: got %0d words left, required 0", exp_ab.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] w [6];
    int idx, guard;
    for (int i = 0; i < 6; i++) w[i] = 32'h100 + 32'(i);
    idx = 0;
    delivered_ab = 0;
    b_rx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      a_tx_valid = (idx < 6);
      a_tx_data  = w[idx < 6 ? idx : 5];
      cycle();
      if (last_a_push) idx++;
    end
    n_checks++;
    if (b_rx_count !== CW'(D) || a_tx_count !== CW'(D) || a_tx_ready !== 1'b0)
      $display("FAIL bp_stall: got rx=%0d tx=%0d tx_ready=%b, required %0d %0d 0",
               b_rx_count, a_tx_count, a_tx_ready, D, D);
    else n_pass++;
    n_checks++;
    if (b_rx_data !== w[0] || link.a_send_data !== w[2])
      $display("FAIL bp_hold: got rx=%h send=%h, required %h %h", b_rx_data, link.a_send_data, w[0], w[2]);
    else n_pass++;
    b_rx_ready = 1'b1;
    guard = 0;
    while (delivered_ab < 6 && guard < 40) begin
      a_tx_valid = (idx < 6);
      a_tx_data  = w[idx < 6 ? idx : 5];
      cycle();
      if (last_a_push) idx++;
      guard++;
    end
    a_tx_valid = 1'b0;
    n_checks++;
    if (delivered_ab != 6) $display("FAIL bp_release: got %0d delivered, required 6", delivered_ab);
    else n_pass++;
  endtask

  task automatic test_wrap_random(input int n);
    int sent_ab, sent_ba, guard;
    delivered_ab = 0; delivered_ba = 0; sent_ab = 0; sent_ba = 0; guard = 0;
    while ((delivered_ab < n || delivered_ba < n) && guard < 50 * n) begin
      a_tx_valid = (sent_ab < n) && ($urandom_range(0, 3) != 0);
      b_tx_valid = (sent_ba < n) && ($urandom_range(0, 3) != 0);
      a_tx_data  = $urandom;
      b_tx_data  = $urandom;
      a_rx_ready = 1'($urandom_range(0, 1));
      b_rx_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_a_push) sent_ab++;
      if (last_b_push) sent_ba++;
      guard++;
    end
    a_tx_valid = 1'b0; b_tx_valid = 1'b0; a_rx_ready = 1'b1; b_rx_ready = 1'b1;
    n_checks++;
    if (delivered_ab != n || delivered_ba != n)
      $display("FAIL wrap_n%0d: got %0d/%0d delivered, required %0d each", n, delivered_ab, delivered_ba, n);
    else n_pass++;
  endtask

  task automatic test_proto_err();
    s_send_done = 1'b1;
    n_checks++;
    if (s_proto_err !== 1'b0) $display("FAIL perr_pre: got %b, required 0", s_proto_err);
    else n_pass++;
    tick();
    s_send_done = 1'b0;
    n_checks++;
    if (s_proto_err !== 1'b1 || s_tx_count !== '0)
      $display("FAIL perr_send: got err=%b tx=%0d, required 1 0", s_proto_err, s_tx_count);
    else n_pass++;
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (s_proto_err !== 1'b1) $display("FAIL perr_sticky: got %b, required 1", s_proto_err);
    else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n_checks++;
    if (s_proto_err !== 1'b0) $display("FAIL perr_clear: got %b, required 0", s_proto_err);
    else n_pass++;
    s_recv_valid = 1'b1; s_recv_data = 32'h11; tick();
    s_recv_data = 32'h22; tick();
    n_checks++;
    if (s_proto_err !== 1'b0 || s_recv_ready !== 1'b0 || s_rx_count !== CW'(D))
      $display("FAIL perr_fill: got err=%b rdy=%b cnt=%0d, required 0 0 %0d",
               s_proto_err, s_recv_ready, s_rx_count, D);
    else n_pass++;
    s_recv_data = 32'h33; tick();
    s_recv_valid = 1'b0;
    n_checks++;
    if (s_proto_err !== 1'b1 || s_rx_count !== CW'(D) || s_rx_data !== 32'h11)
      $display("FAIL perr_recv: got err=%b cnt=%0d head=%h, required 1 %0d 11", s_proto_err, s_rx_count, s_rx_data, D);
    else n_pass++;
    s_rx_ready = 1'b1; tick();
    n_checks++;
    if (s_rx_valid !== 1'b1 || s_rx_data !== 32'h22)
      $display("FAIL perr_order: got v=%b %h, required 1 22", s_rx_valid, s_rx_data);
    else n_pass++;
    tick();
    s_rx_ready = 1'b0;
    n_checks++;
    if (s_rx_valid !== 1'b0) $display("FAIL perr_empty: got %b, required 0", s_rx_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    s_tx_valid = 1'b1; s_tx_data = 32'h1; s_recv_valid = 1'b1; s_recv_data = 32'h3; tick();
    s_tx_data = 32'h2; s_recv_valid = 1'b0; tick();
    s_tx_valid = 1'b0;
    n_checks++;
    if (s_tx_count !== CW'(2) || s_rx_count !== CW'(1))
      $display("FAIL rmid_setup: got tx=%0d rx=%0d, required 2 1", s_tx_count, s_rx_count);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (s_tx_count !== '0 || s_rx_count !== '0 || s_send_ready !== 1'b0 || s_rx_valid !== 1'b0)
      $display("FAIL rmid_async: got tx=%0d rx=%0d sr=%b rv=%b, required 0 0 0 0",
               s_tx_count, s_rx_count, s_send_ready, s_rx_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    s_tx_valid = 1'b1; s_tx_data = 32'hA5; s_recv_valid = 1'b1; s_recv_data = 32'hA5; tick();
    s_tx_valid = 1'b0; s_recv_valid = 1'b0;
    n_checks++;
    if (s_send_ready !== 1'b1 || s_send_data !== 32'hA5 || s_tx_count !== CW'(1))
      $display("FAIL rmid_tx_first: got sr=%b %h cnt=%0d, required 1 a5 1", s_send_ready, s_send_data, s_tx_count);
    else n_pass++;
    n_checks++;
    if (s_rx_valid !== 1'b1 || s_rx_data !== 32'hA5 || s_rx_count !== CW'(1))
      $display("FAIL rmid_rx_first: got rv=%b %h cnt=%0d, required 1 a5 1", s_rx_valid, s_rx_data, s_rx_count);
    else n_pass++;
    s_send_done = 1'b1; s_rx_ready = 1'b1; tick();
    s_send_done = 1'b0; s_rx_ready = 1'b0;
    n_checks++;
    if (s_tx_count !== '0 || s_rx_count !== '0 || s_proto_err !== 1'b0)
      $display("FAIL rmid_drain: got tx=%0d rx=%0d err=%b, required 0 0 0", s_tx_count, s_rx_count, s_proto_err);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    last_a_push = 1'b0; last_b_push = 1'b0;
    delivered_ab = 0; delivered_ba = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_simul_push_pop();
    test_backpressure();
    test_wrap_random(3 * D + 1);
    test_wrap_random(64);
    test_proto_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
